regfile_mp: RTL and testbench

Parametrised multi-port register file: the successor to the single-write, two-read 64-bit `regfile` in the LEGv8 datapath. It adds:
- configurable width, depth and read/write port counts;
- synchronous clear;
- optional same-cycle write-to-read bypass;
- a per-register busy scoreboard for the pipelined core.

It sits between decode (read ports, issue) and writeback (write ports).

---
 rtl/regfile_pkg.sv | 10 +
 rtl/regfile_scoreboard.sv | 29 ++
 rtl/regfile_mp.sv | 43 ++++
 tb/tb_regfile_mp.sv | 134 +++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults, address type and zero-register helper for the register file
package regfile_pkg;
  localparam int WIDTH_DEFAULT = 64;
  localparam int DEPTH_DEFAULT = 32;
  localparam int ZERO_REG_DEFAULT = 31;
  typedef logic [$clog2(DEPTH_DEFAULT)-1:0] reg_addr_t;
  function automatic logic is_zero_reg(input int a, input int zero_reg);
    return a == zero_reg;
  endfunction
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register busy bits tracking in-flight producers
module regfile_scoreboard import regfile_pkg::*; #(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int NREAD = 2,
  parameter int NWRITE = 2,
  parameter int ZERO_REG = ZERO_REG_DEFAULT,
  parameter int BYPASS = 0,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NWRITE-1:0]            we,
  input  logic [NWRITE-1:0][AW-1:0]    wa,
  input  logic [NREAD-1:0][AW-1:0]     ra,
  input  logic                         issue_en,
  input  logic [AW-1:0]                issue_a,
  output logic [NREAD-1:0]             busy
);
  logic [DEPTH-1:0] busy_q, busy_d, clr;
  always_comb begin
    clr = '0;
    for (int j = 0; j < NWRITE; j++) if (we[j]) clr[wa[j]] = 1'b1;
    busy_d = busy_q & ~clr;
    // applied after the clear so a new producer overrides a retiring one
    if (issue_en && !is_zero_reg(int'(issue_a), ZERO_REG)) busy_d[issue_a] = 1'b1;
    for (int i = 0; i < NREAD; i++) busy[i] = busy_q[ra[i]] && !(BYPASS != 0 && clr[ra[i]]);
  end
  always_ff @(posedge clk) busy_q <= reset ? '0 : busy_d;
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with optional write bypass and busy scoreboard
module regfile_mp import regfile_pkg::*; #(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int NREAD = 2,
  parameter int NWRITE = 2,
  parameter int ZERO_REG = ZERO_REG_DEFAULT,
  parameter int BYPASS = 0,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NWRITE-1:0]             we,
  input  logic [NWRITE-1:0][AW-1:0]     wa,
  input  logic [NWRITE-1:0][WIDTH-1:0]  wd,
  input  logic [NREAD-1:0][AW-1:0]      ra,
  output logic [NREAD-1:0][WIDTH-1:0]   rd,
  output logic [NREAD-1:0]              busy,
  input  logic                          issue_en,
  input  logic [AW-1:0]                 issue_a
);
  logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
  always_comb begin
    mem_d = mem_q;
    for (int j = 0; j < NWRITE; j++)
      if (we[j] && !is_zero_reg(int'(wa[j]), ZERO_REG)) mem_d[wa[j]] = wd[j];
  end
  // ascending port order lets the highest enabled port win both storage and bypass
  always_comb begin
    for (int i = 0; i < NREAD; i++) begin
      rd[i] = mem_q[ra[i]];
      for (int j = 0; j < NWRITE; j++) if (BYPASS != 0 && we[j] && wa[j] == ra[i]) rd[i] = wd[j];
      if (is_zero_reg(int'(ra[i]), ZERO_REG)) rd[i] = '0;
    end
  end
  always_ff @(posedge clk) mem_q <= reset ? '0 : mem_d;
  regfile_scoreboard #(
    .DEPTH(DEPTH), .NREAD(NREAD), .NWRITE(NWRITE), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
  ) u_sb (
    .clk(clk), .reset(reset), .we(we), .wa(wa), .ra(ra),
    .issue_en(issue_en), .issue_a(issue_a), .busy(busy)
  );
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed vector bench for regfile_mp with and without bypass plus a small configuration
module tb_regfile_mp;
  typedef struct {
    logic rst;
    logic [1:0] we;
    logic [4:0] wa0, wa1;
    logic [63:0] wd0, wd1;
    logic [4:0] ra0, ra1;
    logic ie;
    logic [4:0] ia;
    logic chk;
    logic [63:0] n0, n1;
    logic [1:0] nb;
    logic [63:0] b0, b1;
    logic [1:0] bb;
  } vec_t;
  logic clk = 1'b0;
  logic reset;
  logic [1:0] we;
  logic [1:0][4:0] wa, ra;
  logic [1:0][63:0] wd, rd_n, rd_b;
  logic [1:0] bz_n, bz_b;
  logic ie;
  logic [4:0] ia;
  logic [0:0] we2;
  logic [0:0][3:0] wa2;
  logic [0:0][31:0] wd2;
  logic [2:0][3:0] ra2;
  logic [2:0][31:0] rd2;
  logic [2:0] bz2;
  logic ie2;
  logic [3:0] ia2;
  int checks = 0;
  int failures = 0;
  vec_t vec[20];
  always #5 clk = ~clk;
  regfile_mp #(.BYPASS(0)) u_nb (
    .clk(clk), .reset(reset), .we(we), .wa(wa), .wd(wd), .ra(ra), .rd(rd_n), .busy(bz_n),
    .issue_en(ie), .issue_a(ia)
  );
  regfile_mp #(.BYPASS(1)) u_b (
    .clk(clk), .reset(reset), .we(we), .wa(wa), .wd(wd), .ra(ra), .rd(rd_b), .busy(bz_b),
    .issue_en(ie), .issue_a(ia)
  );
  regfile_mp #(.WIDTH(32), .DEPTH(16), .NREAD(3), .NWRITE(1), .ZERO_REG(16), .BYPASS(0)) u_p (
    .clk(clk), .reset(reset), .we(we2), .wa(wa2), .wd(wd2), .ra(ra2), .rd(rd2), .busy(bz2),
    .issue_en(ie2), .issue_a(ia2)
  );
  function automatic vec_t mk(int rst, int w, int a0, int a1, int d0, int d1, int r0, int r1,
                              int e, int ea, int c, int n0, int n1, int nb, int b0, int b1, int bb);
    vec_t v;
    v.rst = 1'(rst); v.we = 2'(w); v.wa0 = 5'(a0); v.wa1 = 5'(a1);
    v.wd0 = 64'(d0); v.wd1 = 64'(d1); v.ra0 = 5'(r0); v.ra1 = 5'(r1);
    v.ie = 1'(e); v.ia = 5'(ea); v.chk = 1'(c);
    v.n0 = 64'(n0); v.n1 = 64'(n1); v.nb = 2'(nb);
    v.b0 = 64'(b0); v.b1 = 64'(b1); v.bb = 2'(bb);
    return v;
  endfunction
  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  initial begin
    //          rst we a0 a1 d0     d1    r0 r1 ie ia c  n0     n1     nb b0     b1     bb
    vec[0]  = mk(1, 0, 0, 0, 0,     0,     0, 0, 0, 0, 0, 0,     0,     0, 0,     0,     0);
    vec[1]  = mk(0, 0, 0, 0, 0,     0,     4, 4, 0, 0, 1, 0,     0,     0, 0,     0,     0);
    vec[2]  = mk(0, 1, 4, 0, 127,   0,     4, 4, 0, 0, 1, 0,     0,     0, 127,   127,   0);
    vec[3]  = mk(0, 0, 0, 0, 0,     0,     4, 5, 0, 0, 1, 127,   0,     0, 127,   0,     0);
    vec[4]  = mk(1, 1, 4, 0, 55,    0,     4, 4, 1, 4, 1, 127,   127,   0, 55,    55,    0);
    vec[5]  = mk(0, 0, 0, 0, 0,     0,     4, 5, 0, 0, 1, 0,     0,     0, 0,     0,     0);
    vec[6]  = mk(0, 3, 5, 5, 90,    91241, 5, 4, 0, 0, 1, 0,     0,     0, 91241, 0,     0);
    vec[7]  = mk(0, 0, 0, 0, 0,     0,     5, 4, 0, 0, 1, 91241, 0,     0, 91241, 0,     0);
    vec[8]  = mk(0, 1, 31, 0, 52351, 0,    31, 31, 1, 31, 1, 0,  0,     0, 0,     0,     0);
    vec[9]  = mk(0, 0, 0, 0, 0,     0,     31, 5, 0, 0, 1, 0,    91241, 0, 0,     91241, 0);
    vec[10] = mk(0, 0, 0, 0, 0,     0,     7, 31, 1, 7, 1, 0,    0,     0, 0,     0,     0);
    vec[11] = mk(0, 0, 0, 0, 0,     0,     7, 7, 0, 0, 1, 0,     0,     3, 0,     0,     3);
    vec[12] = mk(0, 2, 0, 7, 0,     5,     7, 5, 1, 7, 1, 0,     91241, 1, 5,     91241, 0);
    vec[13] = mk(0, 0, 0, 0, 0,     0,     7, 7, 0, 0, 1, 5,     5,     3, 5,     5,     3);
    vec[14] = mk(0, 1, 7, 0, 6,     0,     7, 7, 0, 0, 1, 5,     5,     3, 6,     6,     0);
    vec[15] = mk(0, 0, 0, 0, 0,     0,     7, 7, 0, 0, 1, 6,     6,     0, 6,     6,     0);
    vec[16] = mk(0, 3, 9, 9, 11,    22,    9, 7, 1, 9, 1, 0,     6,     0, 22,    6,     0);
    vec[17] = mk(0, 0, 0, 0, 0,     0,     9, 9, 0, 0, 1, 22,    22,    3, 22,    22,    3);
    vec[18] = mk(0, 1, 9, 0, 33,    0,     9, 2, 0, 0, 1, 22,    0,     1, 33,    0,     0);
    vec[19] = mk(0, 0, 0, 0, 0,     0,     9, 9, 0, 0, 1, 33,    33,    0, 33,    33,    0);
    reset = 1'b1; we = '0; wa = '0; wd = '0; ra = '0; ie = 1'b0; ia = '0;
    we2 = '0; wa2 = '0; wd2 = '0; ra2 = '0; ie2 = 1'b0; ia2 = '0;
    @(posedge clk); #1;
    for (int k = 0; k < 20; k++) begin
      reset = vec[k].rst; we = vec[k].we;
      wa[0] = vec[k].wa0; wa[1] = vec[k].wa1; wd[0] = vec[k].wd0; wd[1] = vec[k].wd1;
      ra[0] = vec[k].ra0; ra[1] = vec[k].ra1; ie = vec[k].ie; ia = vec[k].ia;
      @(negedge clk);
      if (vec[k].chk) begin
        check($sformatf("v%0d nb rd0", k), rd_n[0], vec[k].n0);
        check($sformatf("v%0d nb rd1", k), rd_n[1], vec[k].n1);
        check($sformatf("v%0d nb busy", k), 64'(bz_n), 64'(vec[k].nb));
        check($sformatf("v%0d byp rd0", k), rd_b[0], vec[k].b0);
        check($sformatf("v%0d byp rd1", k), rd_b[1], vec[k].b1);
        check($sformatf("v%0d byp busy", k), 64'(bz_b), 64'(vec[k].bb));
      end
      @(posedge clk); #1;
    end
    reset = 1'b0; we = '0; ie = 1'b0;
    ra2[0] = 4'd15; ra2[1] = 4'd15; ra2[2] = 4'd0;
    @(negedge clk);
    check("p reset rd15", 64'(rd2[0]), 64'd0);
    check("p reset rd0", 64'(rd2[2]), 64'd0);
    check("p reset busy", 64'(bz2), 64'd0);
    @(posedge clk); #1;
    we2 = 1'b1; wa2[0] = 4'd15; wd2[0] = 32'hDEADBEEF; ie2 = 1'b1; ia2 = 4'd3;
    @(negedge clk);
    check("p same-cycle rd15", 64'(rd2[0]), 64'd0);
    @(posedge clk); #1;
    we2 = 1'b0; ie2 = 1'b0; ra2[0] = 4'd15; ra2[1] = 4'd15; ra2[2] = 4'd15;
    @(negedge clk);
    for (int i = 0; i < 3; i++) check($sformatf("p rd%0d x15", i), 64'(rd2[i]), 64'hDEADBEEF);
    @(posedge clk); #1;
    we2 = 1'b1; wa2[0] = 4'd0; wd2[0] = 32'h12345678; ra2[0] = 4'd0; ra2[1] = 4'd15; ra2[2] = 4'd3;
    @(negedge clk);
    check("p busy x3", 64'(bz2), 64'b100);
    check("p x0 before edge", 64'(rd2[0]), 64'd0);
    @(posedge clk); #1;
    we2 = 1'b0; ra2[0] = 4'd0; ra2[1] = 4'd0; ra2[2] = 4'd3;
    @(negedge clk);
    check("p rd0 x0", 64'(rd2[0]), 64'h12345678);
    check("p rd1 x0", 64'(rd2[1]), 64'h12345678);
    check("p busy x3 held", 64'(bz2), 64'b100);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
